// File: rtl/isa_pkg.sv
// Shared ISA definitions for the front end: opcode constants, instruction
// width and the fetch buffer entry layout.
package isa_pkg;

    localparam int INSTR_W = 32;
    // PC field width inside a buffer entry; fetch_unit ADDR_W must not exceed it.
    localparam int PC_W    = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    // Opcode field as seen by the control decoder.
    function automatic logic [6:0] opcode_of(input logic [INSTR_W-1:0] w);
        return w[6:0];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/response, redirect from execute
// and the valid/ready handshake toward decode.
interface fetch_unit_if
    import isa_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic [6:0]         opcode;

    // Fetch side.
    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, opcode,
        input  instr_ready
    );

    // Environment side: memory, execute and decode.
    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, opcode,
        output instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push/pop/flush and occupancy count.
// Flush wins over push and pop in the same cycle. Push while full is accepted
// only together with a pop.
module fetch_fifo
    import isa_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory requests, buffered
// words toward decode, and redirect handling with stale-response dropping.
// Optional: FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_unit
    import isa_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc, req_pc;
    logic              outstanding, drop;
    logic              fire, resp, push, pop;
    logic [CW-1:0]     count;
    fetch_entry_t      push_data, head;

    // Space is reserved at request time: one request in flight at most, and
    // only while the buffer has a free slot, so a response always fits.
    assign bus.imem_req  = !rst && !outstanding && (count < CW'(DEPTH)) && !bus.redirect_valid;
    assign bus.imem_addr = pc;

    assign fire = bus.imem_req && bus.imem_gnt;
    assign resp = bus.imem_rvalid && outstanding;
    assign push = resp && !drop && !bus.redirect_valid;
    assign pop  = bus.instr_valid && bus.instr_ready;

    assign push_data.instr = bus.imem_rdata;
    assign push_data.pc    = PC_W'(req_pc);

    assign bus.instr_valid = (count != '0);
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = ADDR_W'(head.pc);
    assign bus.opcode      = opcode_of(head.instr);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (head),
        .count     (count)
    );

    // PC, in-flight tracking and stale-response drop flag; redirect takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc <= bus.redirect_pc & ~ADDR_W'(3);
            if (outstanding) begin
                if (bus.imem_rvalid) begin
                    // Stale word returns right now: swallow it here.
                    outstanding <= 1'b0;
                    drop        <= 1'b0;
                end else begin
                    drop <= 1'b1;
                end
            end
        end else begin
            if (fire) begin
                outstanding <= 1'b1;
                req_pc      <= pc;
                pc          <= pc + ADDR_W'(4);
            end
            if (resp) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Delivered-instruction and decode-stall counters, free-running with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop) perf_fetched <= perf_fetched + 32'd1;
            if (bus.instr_valid && !bus.instr_ready) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects, PC wrap,
// async reset, and the optional perf counters when FETCH_PERF_CNT_EN is set.
module tb_fetch_unit;
    import isa_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    fetch_unit_if #(.ADDR_W(32)) bus ();

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Memory contents: address tag in the top half, opcode chosen by a[3:2].
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [6:0] op;
        case (a[3:2])
            2'd0:    op = OP_R;
            2'd1:    op = OP_I;
            2'd2:    op = OP_LOAD;
            default: op = OP_STORE;
        endcase
        return {a[15:0], 9'h0, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; checks follow 1ns later.
    task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic rdir, input logic [31:0] rpc);
        @(negedge clk);
        bus.imem_gnt       = g;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rd;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rdir;
        bus.redirect_pc    = rpc;
        #1;
    endtask

    initial begin
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        bus.instr_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc", bus.instr_pc, 32'd0);
        chk("rst_opcode", {25'b0, bus.opcode}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_f", perf_fetched, 32'd0);
        chk("rst_perf_s", perf_stall, 32'd0);
`endif
        @(negedge clk); rst = 1'b0;

        // Streaming: gnt, rvalid one cycle later, ready high
        drive(1, 0, 0, 1, 0, 0);
        chk("s_req0", {31'b0, bus.imem_req}, 32'd1);
        chk("s_addr0", bus.imem_addr, 32'h0);
        drive(0, 1, word_at(32'h0), 1, 0, 0);
        chk("s_valid_lat1", {31'b0, bus.instr_valid}, 32'd0);
        chk("s_req_out", {31'b0, bus.imem_req}, 32'd0);
        drive(1, 0, 0, 1, 0, 0);
        chk("s_valid_lat2", {31'b0, bus.instr_valid}, 32'd1);
        chk("s_pc0", bus.instr_pc, 32'h0);
        chk("s_instr0", bus.instr, 32'h0000_0033);
        chk("s_op0", {25'b0, bus.opcode}, 32'h33);
        chk("s_addr4", bus.imem_addr, 32'h4);
        drive(0, 1, word_at(32'h4), 1, 0, 0);
        chk("s_valid_gap", {31'b0, bus.instr_valid}, 32'd0);
        drive(1, 0, 0, 1, 0, 0);
        chk("s_pc4", bus.instr_pc, 32'h4);
        chk("s_instr4", bus.instr, 32'h0004_0013);
        chk("s_op4", {25'b0, bus.opcode}, 32'h13);
        chk("s_addr8", bus.imem_addr, 32'h8);
        drive(0, 1, word_at(32'h8), 1, 0, 0);

        // Back-pressure: ready low fills the 2-entry buffer
        drive(1, 0, 0, 0, 0, 0);
        chk("bp_pc8", bus.instr_pc, 32'h8);
        chk("bp_op8", {25'b0, bus.opcode}, 32'h03);
        chk("bp_addrC", bus.imem_addr, 32'hC);
        drive(0, 1, word_at(32'hC), 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("bp_full_noreq", {31'b0, bus.imem_req}, 32'd0);
        drive(1, 0, 0, 0, 0, 0);
        chk("bp_hold_pc", bus.instr_pc, 32'h8);
        chk("bp_full_noreq2", {31'b0, bus.imem_req}, 32'd0);
        drive(1, 0, 0, 1, 0, 0);
        chk("bp_pop_noreq", {31'b0, bus.imem_req}, 32'd0);
        drive(1, 0, 0, 1, 0, 0);
        chk("bp_req_back", {31'b0, bus.imem_req}, 32'd1);
        chk("bp_addr10", bus.imem_addr, 32'h10);
        chk("bp_pcC", bus.instr_pc, 32'hC);
        chk("bp_instrC", bus.instr, 32'h000C_0023);

        // Redirect while the request for 0x10 is outstanding
        drive(0, 0, 0, 1, 1, 32'h100);
        chk("rd_noreq", {31'b0, bus.imem_req}, 32'd0);
        drive(0, 1, word_at(32'h10), 1, 0, 0);
        chk("rd_wait_stale", {31'b0, bus.imem_req}, 32'd0);
        drive(1, 0, 0, 1, 0, 0);
        chk("rd_stale_dropped", {31'b0, bus.instr_valid}, 32'd0);
        chk("rd_req", {31'b0, bus.imem_req}, 32'd1);
        chk("rd_addr100", bus.imem_addr, 32'h100);
        drive(0, 1, word_at(32'h100), 1, 0, 0);
        drive(1, 0, 0, 1, 0, 0);
        chk("rd_pc100", bus.instr_pc, 32'h100);
        chk("rd_instr100", bus.instr, 32'h0100_0033);
        chk("rd_addr104", bus.imem_addr, 32'h104);

        // Redirect to 0x103 coincident with the stale response
        drive(0, 1, word_at(32'h104), 1, 1, 32'h103);
        chk("rc_noreq", {31'b0, bus.imem_req}, 32'd0);
        drive(0, 0, 0, 1, 0, 0);
        chk("rc_no_push", {31'b0, bus.instr_valid}, 32'd0);
        chk("rc_req", {31'b0, bus.imem_req}, 32'd1);
        chk("rc_addr_aligned", bus.imem_addr, 32'h100);

        // PC wrap at the top of the address space
        drive(0, 0, 0, 1, 1, 32'hFFFF_FFFC);
        drive(1, 0, 0, 1, 0, 0);
        chk("w_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        drive(0, 1, word_at(32'hFFFF_FFFC), 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("w_addr_wrap", bus.imem_addr, 32'h0);
        chk("w_pc_top", bus.instr_pc, 32'hFFFF_FFFC);
        chk("w_instr_top", bus.instr, 32'hFFFC_0023);

        // rvalid with nothing outstanding is ignored
        drive(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
        chk("ign_valid0", {31'b0, bus.instr_valid}, 32'd0);
        drive(0, 0, 0, 1, 0, 0);
        chk("ign_valid1", {31'b0, bus.instr_valid}, 32'd0);

        // Async reset with a request in flight
        drive(1, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        rst = 1'b1; #1;
        chk("ar_req", {31'b0, bus.imem_req}, 32'd0);
        chk("ar_valid", {31'b0, bus.instr_valid}, 32'd0);
        @(negedge clk); rst = 1'b0;
        drive(0, 1, 32'h1234_5678, 1, 0, 0);
        chk("ar_req_after", {31'b0, bus.imem_req}, 32'd1);
        chk("ar_addr_after", bus.imem_addr, 32'h0);
        drive(0, 0, 0, 1, 0, 0);
        chk("ar_stale_ignored", {31'b0, bus.instr_valid}, 32'd0);

        // Five words delivered, three stall cycles on the first one
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            chk("pf_addr", bus.imem_addr, 32'(i * 4));
            drive(0, 1, word_at(32'(i * 4)), 0, 0, 0);
            if (i == 0) begin
                for (int s = 0; s < 3; s++) drive(0, 0, 0, 0, 0, 0);
            end
            drive(0, 0, 0, 1, 0, 0);
            chk("pf_pc", bus.instr_pc, 32'(i * 4));
        end
        drive(0, 0, 0, 1, 0, 0);
        chk("pf_empty", {31'b0, bus.instr_valid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("pf_fetched", perf_fetched, 32'd5);
        chk("pf_stall", perf_stall, 32'd3);
        rst = 1'b1; #1;
        chk("pf_rst_fetched", perf_fetched, 32'd0);
        chk("pf_rst_stall", perf_stall, 32'd0);
        @(negedge clk); rst = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
